ring_phase_monitor: RTL
=======================

Name: ring_phase_monitor

Overview:
Downstream consumer of the 4-phase one-hot ring counter outputs (phase order 0001 -> 0010 -> 0100 -> 1000 -> 0001).
- Checks every sample for one-hot validity and correct rotation order.
- Counts completed revolutions, flags stalls, and reports the current phase index in binary.
- Gives the rest of the design a checked, decoded view of the ring sequencer.

Parameters:
CNT_W, 8, width of revolution counter REV_CNT
STALL_CYCLES, 16, consecutive hold samples before STALL asserts (must be >= 1)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-low (RST=0 at a rising edge resets the block)
PH  input  4  phase vector from ring counter, bit i = phase i
CLR  input  1  synchronous clear of ERR and REV_CNT
PH_IDX  output  2  binary index of last accepted phase
VALID  output  1  1 once a legal phase has been accepted since reset
REV_CNT  output  CNT_W  completed revolutions, modulo 2^CNT_W
REV_WRAP  output  1  one-cycle pulse when REV_CNT wraps from max to 0
ERR  output  1  sticky sequence/encoding error
STALL  output  1  level: phase has held for >= STALL_CYCLES samples

Behaviour:
- **Sampling and latency.** PH is sampled at every rising edge and checked against the previous accepted phase (prev). All outputs are registered and reflect a sample 1 cycle after the edge that sampled it. There is no input register stage.
- **Reset (RST=0 at edge).** prev=0001, PH_IDX=0, VALID=0, REV_CNT=0, REV_WRAP=0, ERR=0, STALL=0, stall timer=0. Reset has priority over all other inputs, including mid-operation.
- **Sample classes** (s = PH):
  - NOHOT: s is not one-hot (0000, 0011, 1111, ...).
  - HOLD: s == prev.
  - ADV: s == rotl(prev) (0001->0010->0100->1000->0001).
  - JUMP: any other one-hot s.
- **VALID=0 (sync phase).** Any one-hot s is accepted unconditionally: prev<=s, PH_IDX<=idx(s), VALID<=1, no count, no ERR. NOHOT sets ERR and leaves VALID=0.
- **VALID=1, HOLD.** Stall timer increments, saturating at STALL_CYCLES. STALL<=1 when the timer reaches STALL_CYCLES.
- **VALID=1, ADV.** prev<=s, PH_IDX<=idx(s), timer<=0, STALL<=0.
  - If prev==1000 and s==0001, REV_CNT increments.
  - At all-ones, REV_CNT wraps to 0 and REV_WRAP=1 for exactly one cycle.
- **VALID=1, JUMP.** ERR<=1. Resynchronise: prev<=s, PH_IDX<=idx(s), timer<=0, STALL<=0, no count.
- **VALID=1, NOHOT.** ERR<=1. prev, PH_IDX, timer and STALL are unchanged (the sample is discarded).
- **ERR** stays sticky until CLR or reset.
- **CLR=1:**
  - REV_CNT<=0, REV_WRAP<=0, ERR<=0.
  - Does not affect prev, PH_IDX, VALID, timer or STALL.
  - Simultaneous CLR + revolution: CLR wins, REV_CNT=0, no REV_WRAP.
  - Simultaneous CLR + new error (NOHOT/JUMP): error wins, ERR=1.
- **Stall timer width:** clog2(STALL_CYCLES+1) bits. It never wraps.

Decomposition:
- Shared package ring_pkg holds:
  - phase constants PH0..PH3 (0001, 0010, 0100, 1000);
  - function rotl4;
  - function onehot4_valid;
  - the sample-class enum NOHOT/HOLD/ADV/JUMP.
- One natural sub-module: ring_phase_classify.
  - Purely combinational.
  - Inputs: PH and prev. Outputs: class and idx(s).
  - The counters and sticky flags stay in ring_phase_monitor.

Test Plan:
1. Reset, then PH=0001,0010,0100,1000,0001 on successive edges -> VALID=1 after first edge; PH_IDX=0,1,2,3,0; REV_CNT=1 one cycle after the final 0001; ERR=0.
2. 256 clean revolutions with CNT_W=8 -> REV_CNT goes 255->0, REV_WRAP=1 for exactly that one cycle; then apply CLR coincident with a 1000->0001 step -> REV_CNT=0, REV_WRAP=0.
3. Sequence at PH_IDX=1, then PH=0011 -> ERR=1, PH_IDX stays 1; then PH=0100 -> accepted as ADV, PH_IDX=2; then CLR -> ERR=0.
4. At prev=0001, PH=0100 (jump) -> ERR=1, PH_IDX=2, no count; then PH=1000 -> ADV, PH_IDX=3.
5. STALL_CYCLES=16, hold PH=0010 after accepting it -> STALL=0 through 15 hold samples, STALL=1 after the 16th; next PH=0100 -> STALL=0, timer 0.
6. Mid-run with REV_CNT=5, ERR=1, STALL=1, then RST=0 for one edge -> all outputs 0, VALID=0; first PH=1000 after release is accepted, PH_IDX=3, ERR=0.

Source files
------------

// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
//   Shared definitions for consumers of the 4-phase one-hot ring counter.
//   Phase order: PH0 (0001) -> PH1 (0010) -> PH2 (0100) -> PH3 (1000) -> PH0.
//
//   Contents:
//     PH0..PH3        phase encodings
//     ph_class_e      classification of one sample against the last
//                     accepted phase (NOHOT / HOLD / ADV / JUMP)
//     rotl4()         one-step rotate-left, i.e. the legal successor phase
//     onehot4_valid() true when exactly one bit of a 4-bit vector is set
//     onehot4_idx()   binary index of a one-hot vector (0 for non-one-hot)
// ---------------------------------------------------------------------------
package ring_pkg;

  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;

  // Sample classes. NOHOT takes precedence over the others: a vector that
  // is not one-hot is never compared against the previous phase.
  typedef enum logic [1:0] {
    NOHOT = 2'd0,
    HOLD  = 2'd1,
    ADV   = 2'd2,
    JUMP  = 2'd3
  } ph_class_e;

  // Legal successor of a phase: bit 3 wraps around into bit 0.
  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Exactly one bit set: non-zero, and clearing the lowest set bit
  // leaves nothing behind.
  function automatic logic onehot4_valid(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Binary index of a one-hot vector. Non-one-hot inputs map to 0; callers
  // only use the result when the vector has already been validated.
  function automatic logic [1:0] onehot4_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (v)
      PH0:     idx = 2'd0;
      PH1:     idx = 2'd1;
      PH2:     idx = 2'd2;
      PH3:     idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ring_phase_classify.sv
// ---------------------------------------------------------------------------
// ring_phase_classify
//   Purely combinational classifier for one ring-counter sample.
//
//   Ports:
//     ph_i    [3:0]  current sample from the ring counter
//     prev_i  [3:0]  last accepted phase (always one-hot)
//     cls_o          sample class: NOHOT / HOLD / ADV / JUMP
//     idx_o   [1:0]  binary index of ph_i (meaningful only when one-hot)
// ---------------------------------------------------------------------------
module ring_phase_classify
  import ring_pkg::*;
(
  input  logic [3:0] ph_i,
  input  logic [3:0] prev_i,
  output ph_class_e  cls_o,
  output logic [1:0] idx_o
);

  logic ph_onehot;

  always_comb begin
    ph_onehot = onehot4_valid(ph_i);
    cls_o     = NOHOT;
    if (!ph_onehot) begin
      cls_o = NOHOT;
    end else if (ph_i == prev_i) begin
      cls_o = HOLD;
    end else if (ph_i == rotl4(prev_i)) begin
      cls_o = ADV;
    end else begin
      cls_o = JUMP;
    end
  end

  always_comb begin
    idx_o = onehot4_idx(ph_i);
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// ---------------------------------------------------------------------------
// ring_phase_monitor
//   Checked, decoded view of a 4-phase one-hot ring sequencer. Every rising
//   edge samples PH (no input register) and compares it with the last
//   accepted phase. All outputs are registered, so each reflects the sample
//   taken at the previous rising edge.
//
//   Parameters:
//     CNT_W         width of the revolution counter
//     STALL_CYCLES  consecutive HOLD samples before STALL asserts (>= 1)
//
//   Ports:
//     CLK       clock, all state changes on the rising edge
//     RST       synchronous reset, active low; beats every other input
//     PH        [3:0] phase vector, bit i = phase i
//     CLR       synchronous clear of ERR, REV_CNT and REV_WRAP
//     PH_IDX    [1:0] binary index of the last accepted phase
//     VALID     a legal phase has been accepted since reset
//     REV_CNT   [CNT_W-1:0] completed revolutions (PH3 -> PH0 steps), modulo
//     REV_WRAP  single-cycle pulse when REV_CNT wraps from all-ones to 0
//     ERR       sticky: a NOHOT sample, or a JUMP while synchronised
//     STALL     level: phase has held for >= STALL_CYCLES samples
//
//   Operating modes (tracked by VALID):
//     VALID=0  synchronising: the first one-hot sample is accepted as-is.
//              NOHOT samples raise ERR and keep the block unsynchronised.
//     VALID=1  tracking: HOLD runs the stall timer, ADV moves forward (and
//              counts a revolution on PH3 -> PH0), JUMP raises ERR and
//              resynchronises to the new phase, NOHOT raises ERR and is
//              otherwise ignored.
// ---------------------------------------------------------------------------
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int STALL_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       PH,
  input  logic             CLR,
  output logic [1:0]       PH_IDX,
  output logic             VALID,
  output logic [CNT_W-1:0] REV_CNT,
  output logic             REV_WRAP,
  output logic             ERR,
  output logic             STALL
);

  // Timer just wide enough to hold STALL_CYCLES; it saturates there.
  localparam int TIMER_W = $clog2(STALL_CYCLES + 1);
  localparam logic [TIMER_W-1:0] STALL_MAX = TIMER_W'(STALL_CYCLES);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [3:0]         prev_q,     prev_d;
  logic [1:0]         ph_idx_q,   ph_idx_d;
  logic               valid_q,    valid_d;
  logic [CNT_W-1:0]   rev_cnt_q,  rev_cnt_d;
  logic               rev_wrap_q, rev_wrap_d;
  logic               err_q,      err_d;
  logic               stall_q,    stall_d;
  logic [TIMER_W-1:0] timer_q,    timer_d;

  // -------------------------------------------------------------------------
  // Sample classification
  // -------------------------------------------------------------------------
  ph_class_e  sample_cls;
  logic [1:0] sample_idx;

  ring_phase_classify u_classify (
    .ph_i   (PH),
    .prev_i (prev_q),
    .cls_o  (sample_cls),
    .idx_o  (sample_idx)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic err_set;   // this sample is an error (NOHOT, or JUMP while synced)
  logic rev_inc;   // this sample completes a revolution (PH3 -> PH0 ADV)

  always_comb begin
    prev_d     = prev_q;
    ph_idx_d   = ph_idx_q;
    valid_d    = valid_q;
    rev_cnt_d  = rev_cnt_q;
    rev_wrap_d = 1'b0;           // pulse: only high for the wrapping cycle
    err_d      = err_q;
    stall_d    = stall_q;
    timer_d    = timer_q;
    err_set    = 1'b0;
    rev_inc    = 1'b0;

    if (!valid_q) begin
      // Synchronising: any one-hot sample is taken as the starting phase,
      // whether or not it follows the reset value of prev.
      if (sample_cls == NOHOT) begin
        err_set = 1'b1;
      end else begin
        prev_d   = PH;
        ph_idx_d = sample_idx;
        valid_d  = 1'b1;
        timer_d  = '0;
        stall_d  = 1'b0;
      end
    end else begin
      unique case (sample_cls)
        HOLD: begin
          if (timer_q != STALL_MAX) begin
            timer_d = timer_q + TIMER_W'(1);
          end
          stall_d = (timer_d == STALL_MAX);
        end
        ADV: begin
          prev_d   = PH;
          ph_idx_d = sample_idx;
          timer_d  = '0;
          stall_d  = 1'b0;
          rev_inc  = (prev_q == PH3) && (PH == PH0);
        end
        JUMP: begin
          // Resynchronise to the new phase so tracking can continue.
          err_set  = 1'b1;
          prev_d   = PH;
          ph_idx_d = sample_idx;
          timer_d  = '0;
          stall_d  = 1'b0;
        end
        NOHOT: begin
          // Discard the sample entirely; only the error is recorded.
          err_set = 1'b1;
        end
        default: begin
          err_set = 1'b1;
        end
      endcase
    end

    if (rev_inc) begin
      rev_cnt_d  = rev_cnt_q + CNT_W'(1);
      rev_wrap_d = &rev_cnt_q;
    end

    // CLR beats a coincident revolution, but a coincident error still
    // leaves ERR set so it cannot be lost by a badly timed clear.
    if (CLR) begin
      rev_cnt_d  = '0;
      rev_wrap_d = 1'b0;
      err_d      = 1'b0;
    end

    if (err_set) begin
      err_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prev_q     <= PH0;
      ph_idx_q   <= 2'd0;
      valid_q    <= 1'b0;
      rev_cnt_q  <= '0;
      rev_wrap_q <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      timer_q    <= '0;
    end else begin
      prev_q     <= prev_d;
      ph_idx_q   <= ph_idx_d;
      valid_q    <= valid_d;
      rev_cnt_q  <= rev_cnt_d;
      rev_wrap_q <= rev_wrap_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      timer_q    <= timer_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign PH_IDX   = ph_idx_q;
  assign VALID    = valid_q;
  assign REV_CNT  = rev_cnt_q;
  assign REV_WRAP = rev_wrap_q;
  assign ERR      = err_q;
  assign STALL    = stall_q;

endmodule
